onehot_rr_arbiter: RTL and testbench

ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

---
 rtl/onehot_rr_arbiter_if.sv | 25 ++
 rtl/onehot_rr_arbiter.sv | 91 +++++++++
 tb/tb_onehot_rr_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The requesters drive req and done. The arbiter drives the registered grant outputs.
interface onehot_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_id,
    input  grant_valid
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_id,
    output grant_valid
  );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Eight-way round-robin arbiter with one-hot grant and a bounded hold time.
// After every release the arbiter idles for one cycle before it makes a new grant.
module onehot_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input logic                clk,
  input logic                rst,
  onehot_rr_arbiter_if.slave bus
);

  localparam logic       StIdle   = 1'b0;
  localparam logic       StGrant  = 1'b1;
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic       state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] grant_id_q, grant_id_d;
  logic       grant_valid_q, grant_valid_d;
  logic [7:0] grant_q, grant_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic       pick_found;
  logic [2:0] pick_id;
  logic       release_now;

  // The scan runs from ptr+7 down to ptr, so the set bit closest to ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr_q + 3'(k)]) begin
        pick_found = 1'b1;
        pick_id    = ptr_q + 3'(k);
      end
    end
  end

  assign release_now = bus.done | ~bus.req[grant_id_q] | (hold_cnt_q == HoldLast);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    grant_d       = grant_q;
    hold_cnt_d    = hold_cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d       = StGrant;
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          grant_d       = 8'b1 << pick_id;
          hold_cnt_d    = 8'd0;
        end
      end
      StGrant: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (release_now) begin
          state_d       = StIdle;
          grant_valid_d = 1'b0;
          grant_d       = 8'h00;
          ptr_d         = grant_id_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= 3'd0;
      grant_id_q    <= 3'd0;
      grant_valid_q <= 1'b0;
      grant_q       <= 8'h00;
      hold_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter. Two instances (MAX_HOLD 15 and 4) share one stimulus stream.
// Each instance is checked against its own behavioural model on every cycle.
module tb_onehot_rr_arbiter;

  logic clk;
  logic rst;

  onehot_rr_arbiter_if ifa ();
  onehot_rr_arbiter_if ifb ();

  onehot_rr_arbiter #(.MAX_HOLD(15)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  onehot_rr_arbiter #(.MAX_HOLD(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       drv_rst;
  logic [7:0] drv_req;
  logic       drv_done;

  // The model state is indexed by instance: 0 is dut_a, 1 is dut_b.
  int maxh    [2] = '{15, 4};
  int m_valid [2];
  int m_id    [2];
  int m_ptr   [2];
  int m_run   [2];
  int dut_run [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      if (drv_rst) begin
        m_valid[u] = 0; m_id[u] = 0; m_ptr[u] = 0; m_run[u] = 0;
      end else if (m_valid[u] == 0) begin
        for (int k = 0; k < 8; k++) begin
          int idx;
          idx = (m_ptr[u] + k) % 8;
          if (drv_req[idx] && m_valid[u] == 0) begin
            m_valid[u] = 1; m_id[u] = idx; m_run[u] = 1;
          end
        end
      end else if (drv_done || !drv_req[m_id[u]] || m_run[u] == maxh[u]) begin
        m_valid[u] = 0;
        m_ptr[u]   = (m_id[u] + 1) % 8;
      end else begin
        m_run[u]++;
      end
    end
  endtask

  task automatic check_inst(input int u, input string tag, input logic [7:0] g,
                            input logic [2:0] gid, input logic gv);
    logic [7:0] exp_g;
    exp_g = (m_valid[u] != 0) ? 8'(1 << m_id[u]) : 8'h00;
    check({tag, " grant"}, 32'(g), 32'(exp_g));
    check({tag, " grant_id"}, 32'(gid), 32'(m_id[u]));
    check({tag, " grant_valid"}, 32'(gv), 32'(m_valid[u] != 0));
    check({tag, " onehot"}, 32'((g == 8'h00) || (g == 8'(1 << gid) && gv)), 32'd1);
    dut_run[u] = gv ? dut_run[u] + 1 : 0;
    check({tag, " hold bound"}, 32'(dut_run[u] <= maxh[u]), 32'd1);
  endtask

  task automatic cycle(input logic r, input logic [7:0] rq, input logic d);
    drv_rst = r; drv_req = rq; drv_done = d;
    rst = r;
    ifa.req = rq; ifb.req = rq;
    ifa.done = d; ifb.done = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_inst(0, "A", ifa.grant, ifa.grant_id, ifa.grant_valid);
    check_inst(1, "B", ifb.grant, ifb.grant_id, ifb.grant_valid);
  endtask

  initial begin
    int pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [7:0] rq;
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 0; m_id[u] = 0; m_ptr[u] = 0; m_run[u] = 0; dut_run[u] = 0;
    end
    rst = 1'b1;
    ifa.req = 8'h00; ifb.req = 8'h00; ifa.done = 1'b0; ifb.done = 1'b0;
    @(negedge clk);

    // Reset state
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    check("reset grant", 32'(ifa.grant), 32'h00);
    check("reset grant_id", 32'(ifa.grant_id), 32'd0);
    check("reset valid", 32'(ifb.grant_valid), 32'd0);

    // Single request, then release with done
    cycle(1'b0, 8'h08, 1'b0);
    check("single grant", 32'(ifa.grant), 32'h08);
    check("single id", 32'(ifa.grant_id), 32'd3);
    check("single valid", 32'(ifa.grant_valid), 32'd1);
    cycle(1'b0, 8'h08, 1'b1);
    check("single release", 32'(ifa.grant), 32'h00);
    cycle(1'b0, 8'h00, 1'b1);

    // Timeout on dut_b (MAX_HOLD=4): 4 cycles on, 1 cycle off
    cycle(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h01, 1'b0);
      check("timeout B pattern", 32'(ifb.grant), 32'(pat[i]));
      check("timeout A held", 32'(ifa.grant), 32'h01);
    end

    // Round robin with all requests held
    cycle(1'b1, 8'h00, 1'b0);
    for (int g = 0; g < 9; g++) begin
      cycle(1'b0, 8'hFF, 1'b0);
      check("rr id", 32'(ifa.grant_id), 32'(g % 8));
      check("rr id B", 32'(ifb.grant_id), 32'(g % 8));
      cycle(1'b0, 8'hFF, 1'b1);
      check("rr idle gap", 32'(ifa.grant), 32'h00);
    end

    // Wrap and skip: owner 6 releases with req=05
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h40, 1'b0);
    check("wrap owner", 32'(ifa.grant_id), 32'd6);
    cycle(1'b0, 8'h05, 1'b0);
    check("wrap release", 32'(ifa.grant_valid), 32'd0);
    cycle(1'b0, 8'h05, 1'b0);
    check("wrap next id", 32'(ifa.grant_id), 32'd0);
    cycle(1'b0, 8'h05, 1'b1);
    cycle(1'b0, 8'h05, 1'b0);
    check("skip next id", 32'(ifa.grant_id), 32'd2);

    // Withdrawal, then reset in the middle of a grant
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h08, 1'b0);
    check("withdraw owner", 32'(ifa.grant), 32'h08);
    cycle(1'b0, 8'h00, 1'b0);
    check("withdraw clear", 32'(ifa.grant), 32'h00);
    cycle(1'b0, 8'hFF, 1'b0);
    check("post withdraw id", 32'(ifa.grant_id), 32'd4);
    cycle(1'b1, 8'hFF, 1'b0);
    check("mid rst grant", 32'(ifa.grant), 32'h00);
    check("mid rst id", 32'(ifa.grant_id), 32'd0);
    cycle(1'b0, 8'hFF, 1'b0);
    check("after rst id", 32'(ifa.grant_id), 32'd0);

    // Randomized traffic
    rq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rq = 8'h00;
      cycle(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
